// File: rtl/block_mean_store_if.sv
// Port bundle for block_mean_store: mean stream in, frame sync, random-access read port.
// master = producer/reader side, slave = the frame store.
interface block_mean_store_if #(
    parameter int DW = 8
);
    logic          vs;
    logic [DW-1:0] mean_in;
    logic          mean_valid;
    logic          rd_en;
    logic [5:0]    rd_x;
    logic [4:0]    rd_y;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_ready;
    logic          frame_err;

    modport master (
        output vs, mean_in, mean_valid, rd_en, rd_x, rd_y,
        input  rd_data, rd_valid, frame_ready, frame_err
    );

    modport slave (
        input  vs, mean_in, mean_valid, rd_en, rd_x, rd_y,
        output rd_data, rd_valid, frame_ready, frame_err
    );
endinterface

// File: rtl/block_mean_store.sv
// Ping-pong store of per-block luminance means with 1-cycle random-access reads.
// Optional BLOCK_MEAN_TEMPORAL_FILTER_EN: IIR-blend each new mean with the displayed frame.
module block_mean_store #(
    parameter int BLK_COLS = 40,
    parameter int BLK_ROWS = 20,
    parameter int DW       = 8
) (
    input  logic              clk,
    input  logic              rst,
    block_mean_store_if.slave bus
);
    localparam int            NBLK   = BLK_COLS * BLK_ROWS;
    localparam int            AW     = 10;
    localparam logic [AW-1:0] COLS_V = AW'(BLK_COLS);
    localparam logic [AW-1:0] NBLK_V = AW'(NBLK);
    localparam logic [5:0]    COLS6  = 6'(BLK_COLS);
    localparam logic [4:0]    ROWS5  = 5'(BLK_ROWS);

    // row*BLK_COLS + col as a constant shift-add over the set bits of BLK_COLS
    function automatic logic [AW-1:0] blk_addr(input logic [4:0] row, input logic [5:0] col);
        logic [AW-1:0] acc;
        acc = AW'(col);
        for (int b = 0; b < AW; b++)
            if (COLS_V[b]) acc = acc + (AW'(row) << b);
        return acc;
    endfunction

    logic [DW-1:0] mem0 [NBLK];
    logic [DW-1:0] mem1 [NBLK];

    logic          vs_d_q;
    logic [5:0]    wr_col_q, wr_col_d;
    logic [4:0]    wr_row_q, wr_row_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          ovr_q, ovr_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          first_done_q, first_done_d;
    logic          frame_ready_q, frame_ready_d;
    logic          frame_err_q, frame_err_d;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic          vs_rise, frame_ok;
    logic [5:0]    col_b;
    logic [4:0]    row_b;
    logic [AW-1:0] cnt_b;
    logic          ovr_b;
    logic          we;
    logic [AW-1:0] waddr;

    logic          mem_we;
    logic          mem_bank;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic [AW-1:0] raddr;
    logic          oob;
    logic [DW-1:0] rd_word;

    // Frame boundary is resolved first so a coincident sample lands at address 0 of the new bank.
    always_comb begin
        vs_rise  = bus.vs & ~vs_d_q;
        frame_ok = (wr_cnt_q == NBLK_V) && !ovr_q;

        col_b = vs_rise ? '0 : wr_col_q;
        row_b = vs_rise ? '0 : wr_row_q;
        cnt_b = vs_rise ? '0 : wr_cnt_q;
        ovr_b = vs_rise ? 1'b0 : ovr_q;

        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        first_done_d  = first_done_q;
        frame_ready_d = vs_rise & frame_ok;
        frame_err_d   = vs_rise & ~frame_ok;
        if (vs_rise && frame_ok) begin
            rd_bank_d    = wr_bank_q;
            wr_bank_d    = ~wr_bank_q;
            first_done_d = 1'b1;
        end

        wr_col_d = col_b;
        wr_row_d = row_b;
        wr_cnt_d = cnt_b;
        ovr_d    = ovr_b;
        we       = 1'b0;
        waddr    = blk_addr(row_b, col_b);
        if (bus.mean_valid && !rst) begin
            if (cnt_b == NBLK_V) begin
                ovr_d = 1'b1;
            end else if (!ovr_b) begin
                we       = 1'b1;
                wr_cnt_d = cnt_b + 1'b1;
                if (col_b == COLS6 - 6'd1) begin
                    wr_col_d = '0;
                    wr_row_d = row_b + 5'd1;
                end else begin
                    wr_col_d = col_b + 6'd1;
                end
            end
        end
    end

`ifdef BLOCK_MEAN_TEMPORAL_FILTER_EN
    logic          wp_vld_q;
    logic          wp_bank_q;
    logic [AW-1:0] wp_addr_q;
    logic [DW-1:0] wp_mean_q;
    logic [DW-1:0] wp_prev_q;
    logic          wp_filt_q;
    logic [DW-1:0] prev_d;
    logic [9:0]    filt_sum;
    logic [9:0]    filt_q;

    // Stage 0 fetches prev from the displayed bank; stage 1 blends and writes.
    always_comb begin
        filt_sum = 10'(wp_prev_q) + (10'(wp_prev_q) << 1) + 10'(wp_mean_q) + 10'd2;
        filt_q   = filt_sum >> 2;

        mem_we    = wp_vld_q;
        mem_bank  = wp_bank_q;
        mem_addr  = wp_addr_q;
        mem_wdata = wp_mean_q;
        if (wp_filt_q)
            mem_wdata = (filt_q > 10'd255) ? DW'(255) : DW'(filt_q);

        prev_d = rd_bank_d ? mem1[waddr] : mem0[waddr];
        if (wp_vld_q && wp_bank_q == rd_bank_d && wp_addr_q == waddr)
            prev_d = mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) wp_vld_q <= 1'b0;
        else     wp_vld_q <= we;
        wp_bank_q <= wr_bank_d;
        wp_addr_q <= waddr;
        wp_mean_q <= bus.mean_in;
        wp_prev_q <= prev_d;
        wp_filt_q <= first_done_d;
    end
`else
    always_comb begin
        mem_we    = we;
        mem_bank  = wr_bank_d;
        mem_addr  = waddr;
        mem_wdata = bus.mean_in;
    end
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (mem_bank) mem1[mem_addr] <= mem_wdata;
            else          mem0[mem_addr] <= mem_wdata;
        end
    end

    // Reads always use the pre-update rd_bank, so a read in a swap cycle sees the old frame.
    always_comb begin
        raddr   = blk_addr(bus.rd_y, bus.rd_x);
        oob     = (bus.rd_x >= COLS6) || (bus.rd_y >= ROWS5);
        rd_word = '0;
        if (!oob) rd_word = rd_bank_q ? mem1[raddr] : mem0[raddr];
`ifdef BLOCK_MEAN_TEMPORAL_FILTER_EN
        // last write of a just-swapped frame may still be in flight
        if (!oob && mem_we && mem_bank == rd_bank_q && mem_addr == raddr)
            rd_word = mem_wdata;
`endif
        rd_data_d = (oob || !first_done_q) ? '0 : rd_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d_q        <= 1'b0;
            wr_col_q      <= '0;
            wr_row_q      <= '0;
            wr_cnt_q      <= '0;
            ovr_q         <= 1'b0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            first_done_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_err_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            vs_d_q        <= bus.vs;
            wr_col_q      <= wr_col_d;
            wr_row_q      <= wr_row_d;
            wr_cnt_q      <= wr_cnt_d;
            ovr_q         <= ovr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            first_done_q  <= first_done_d;
            frame_ready_q <= frame_ready_d;
            frame_err_q   <= frame_err_d;
            rd_valid_q    <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_block_mean_store.sv
// Randomized scoreboard bench for block_mean_store (default build, filter disabled).
module tb_block_mean_store;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_mean_store_if #(.DW(8)) bus();

    block_mean_store #(.BLK_COLS(40), .BLK_ROWS(20), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct { logic [7:0] data; int due; } rd_exp_t;
    typedef struct { bit err; int due; } ev_exp_t;

    rd_exp_t exp_rd[$];
    ev_exp_t exp_ev[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: a frame being filled and the frame on display, as flat row-major arrays.
    logic [7:0] pend [800];
    logic [7:0] vis  [800];
    bit  shown   = 0;
    int  cnt     = 0;
    bit  ovr     = 0;
    bit  vs_prev = 0;

    always @(posedge clk) cyc++;

    task automatic step(input bit vs, input bit mv, input logic [7:0] m,
                        input bit re, input int x, input int y);
        rd_exp_t r;
        ev_exp_t e;
        @(posedge clk);
        #2;
        bus.vs = vs; bus.mean_valid = mv; bus.mean_in = m;
        bus.rd_en = re; bus.rd_x = 6'(x); bus.rd_y = 5'(y);
        if (re) begin
            r.due  = cyc + 1;
            r.data = (x < 40 && y < 20 && shown) ? vis[y*40 + x] : 8'h00;
            exp_rd.push_back(r);
        end
        if (vs && !vs_prev) begin
            e.due = cyc + 1;
            if (cnt == 800 && !ovr) begin
                vis = pend; shown = 1; e.err = 0;
            end else begin
                e.err = 1;
            end
            exp_ev.push_back(e);
            cnt = 0; ovr = 0;
        end
        vs_prev = vs;
        if (mv) begin
            if (cnt == 800) ovr = 1;
            else begin pend[cnt] = m; cnt++; end
        end
    endtask

    task automatic pick(output bit re, output int x, output int y);
        re = ($urandom_range(0, 99) < 30);
        x  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39));
        y  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
    endtask

    // mode 0 = random bytes, 1 = index pattern, 2 = constant val
    task automatic send_frame(input int n, input int mode, input logic [7:0] val, input int gap_max);
        bit re; int x, y, g; logic [7:0] m;
        for (int i = 0; i < n; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < g; k++) begin
                pick(re, x, y); step(0, 0, 8'h00, re, x, y);
            end
            m = (mode == 0) ? 8'($urandom) : (mode == 1) ? 8'(i) : val;
            pick(re, x, y);
            step(0, 1, m, re, x, y);
        end
    endtask

    task automatic vs_pulse(input int hi);
        bit re; int x, y;
        for (int k = 0; k < hi; k++) begin
            pick(re, x, y); step(1, 0, 8'h00, re, x, y);
        end
        pick(re, x, y); step(0, 0, 8'h00, re, x, y);
    endtask

    task automatic rand_reads(input int n);
        int x, y; bit re;
        for (int k = 0; k < n; k++) begin
            pick(re, x, y); step(0, 0, 8'h00, 1, x, y);
        end
    endtask

    // Monitor: every output event must match the head of its queue on its due cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_rd.size() > 0 && exp_rd[0].due == cyc) begin
                checks++;
                if (!bus.rd_valid || bus.rd_data !== exp_rd[0].data) begin
                    errors++;
                    $display("FAIL read cyc=%0d got valid=%0b data=%02h expected valid=1 data=%02h",
                             cyc, bus.rd_valid, bus.rd_data, exp_rd[0].data);
                end
                void'(exp_rd.pop_front());
            end else if (bus.rd_valid) begin
                checks++; errors++;
                $display("FAIL read_spurious cyc=%0d got rd_valid=1 expected 0", cyc);
            end
            if (exp_ev.size() > 0 && exp_ev[0].due == cyc) begin
                checks++;
                if (bus.frame_ready !== !exp_ev[0].err || bus.frame_err !== exp_ev[0].err) begin
                    errors++;
                    $display("FAIL frame_event cyc=%0d got ready=%0b err=%0b expected ready=%0b err=%0b",
                             cyc, bus.frame_ready, bus.frame_err, !exp_ev[0].err, exp_ev[0].err);
                end
                void'(exp_ev.pop_front());
            end else if (bus.frame_ready || bus.frame_err) begin
                checks++; errors++;
                $display("FAIL frame_spurious cyc=%0d got ready=%0b err=%0b expected 0 0",
                         cyc, bus.frame_ready, bus.frame_err);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.vs = 0; bus.mean_valid = 0; bus.mean_in = 0;
        bus.rd_en = 0; bus.rd_x = 0; bus.rd_y = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 ||
            bus.frame_ready !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got valid=%0b data=%02h ready=%0b err=%0b expected all 0",
                     bus.rd_valid, bus.rd_data, bus.frame_ready, bus.frame_err);
        end

        // no frame yet: reads return 0
        step(0, 0, 8'h00, 1, 0, 0);
        rand_reads(5);

        // index-pattern frame, then swap
        send_frame(800, 1, 8'h00, 0);
        vs_pulse(1);
        step(0, 0, 8'h00, 1, 39, 19);
        step(0, 0, 8'h00, 1, 5, 2);
        step(0, 0, 8'h00, 1, 40, 0);
        rand_reads(20);

        // short frame: error, old frame stays
        send_frame(799, 0, 8'h00, 1);
        vs_pulse(2);
        rand_reads(20);

        // full constant frame
        send_frame(800, 2, 8'hAA, 0);
        vs_pulse(1);
        rand_reads(30);

        // overrun frame: error, no swap
        send_frame(801, 0, 8'h00, 0);
        vs_pulse(1);
        rand_reads(20);

        // full random frame, then boundary coincident with first sample 0x33
        send_frame(800, 0, 8'h00, 2);
        step(1, 1, 8'h33, 1, 0, 0);
        send_frame(799, 0, 8'h00, 0);
        vs_pulse(1);
        step(0, 0, 8'h00, 1, 0, 0);
        rand_reads(20);

        // randomized frame lengths and vs widths
        for (int f = 0; f < 5; f++) begin
            send_frame((f % 2 == 0) ? 800 : int'($urandom_range(795, 803)), 0, 8'h00, 1);
            vs_pulse(int'($urandom_range(1, 3)));
            rand_reads(15);
        end

        repeat (4) step(0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (exp_rd.size() != 0 || exp_ev.size() != 0) begin
            errors++;
            $display("FAIL drain got pending reads=%0d events=%0d expected 0 0",
                     exp_rd.size(), exp_ev.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
